// File: rtl/sw_seq_feeder.sv
// sw_seq_feeder: data-processor side of the PE-array controller's sequence interface.
//
// Stores the query S as PE-array-wide chunks and the target T as a {t,v,f} stream. Both are served
// to the controller on update strobes. The {t,v,f} written back during each pass is captured in a
// ping-pong bank, and that bank becomes the read stream for the next S chunk.
//
// Ports:
//   clk, rst                        clock (rising edge), synchronous active-high reset
//   i_ld_s_valid / i_ld_s_data      append one S chunk (IDLE only)
//   i_ld_t_valid / i_ld_t_data      append one T base into bank0 as {t,0,0} (IDLE only)
//   i_start                         begin serving (IDLE only, both lengths non-zero)
//   o_busy, o_done, o_err           serving / one-cycle completion pulse / sticky protocol error
//   o_data_valid                    o_s and o_t/o_v/o_f are valid
//   i_update_s_w                    advance to next S chunk (pass must be fully written back)
//   o_s, o_s_last                   current S chunk, final-chunk flag
//   i_update_t_w, i_t, i_v, i_f     consume current element and write back {t,v,f}
//   o_t, o_v, o_f, o_t_last         current element, final-element flag
module sw_seq_feeder #(
  parameter int unsigned PE_ARRAY_SIZE = 64,
  parameter int unsigned VEF_BIT       = 10,
  parameter int unsigned T_DEPTH       = 1024,
  parameter int unsigned S_DEPTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_ld_s_valid,
  input  logic [PE_ARRAY_SIZE*2-1:0] i_ld_s_data,
  input  logic                       i_ld_t_valid,
  input  logic [1:0]                 i_ld_t_data,
  input  logic                       i_start,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err,
  output logic                       o_data_valid,
  input  logic                       i_update_s_w,
  output logic [PE_ARRAY_SIZE*2-1:0] o_s,
  output logic                       o_s_last,
  input  logic                       i_update_t_w,
  input  logic [1:0]                 i_t,
  input  logic [VEF_BIT-1:0]         i_v,
  input  logic [VEF_BIT-1:0]         i_f,
  output logic [1:0]                 o_t,
  output logic [VEF_BIT-1:0]         o_v,
  output logic [VEF_BIT-1:0]         o_f,
  output logic                       o_t_last
);

  localparam int unsigned AW    = $clog2(T_DEPTH);
  localparam int unsigned SW    = $clog2(S_DEPTH);
  localparam int unsigned SBits = PE_ARRAY_SIZE * 2;
  localparam int unsigned EW    = 2 + 2 * VEF_BIT;

  // Lengths and pointers carry one extra bit so they can reach the full depth.
  localparam logic [AW:0] TCap = (AW + 1)'(T_DEPTH);
  localparam logic [SW:0] SCap = (SW + 1)'(S_DEPTH);
  localparam logic [AW:0] TOne = (AW + 1)'(1);
  localparam logic [SW:0] SOne = (SW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StPresent, StServe} state_e;

  // Storage
  logic [SBits-1:0] s_ram [S_DEPTH];
  logic [EW-1:0]    bank0 [T_DEPTH];
  logic [EW-1:0]    bank1 [T_DEPTH];

  // State
  state_e            state_q, state_d;
  logic [SW:0]       s_len_q, s_len_d;
  logic [AW:0]       t_len_q, t_len_d;
  logic [SW:0]       s_ptr_q, s_ptr_d;
  logic [AW:0]       t_rd_q, t_rd_d;
  logic [AW:0]       t_wr_q, t_wr_d;
  logic              bank_sel_q, bank_sel_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [SBits-1:0]  s_out_q, s_out_d;
  logic [EW-1:0]     e_out_q, e_out_d;

  // Memory controls
  logic              s_we;
  logic              ld_t_we;
  logic              wb_we;
  logic [EW-1:0]     wb_data;
  logic [AW-1:0]     rd_idx;
  logic [EW-1:0]     rd_elem;

  assign wb_data = {i_t, i_v, i_f};

  // In SERVE the read port looks one element ahead so a strobe can load the next element
  // straight into the output register; in PRESENT it fetches the element at t_rd.
  always_comb begin
    rd_idx  = t_rd_q[AW-1:0] + AW'(state_q == StServe);
    rd_elem = bank_sel_q ? bank1[rd_idx] : bank0[rd_idx];
  end

  always_comb begin
    state_d    = state_q;
    s_len_d    = s_len_q;
    t_len_d    = t_len_q;
    s_ptr_d    = s_ptr_q;
    t_rd_d     = t_rd_q;
    t_wr_d     = t_wr_q;
    bank_sel_d = bank_sel_q;
    err_d      = err_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    s_out_d    = s_out_q;
    e_out_d    = e_out_q;
    s_we       = 1'b0;
    ld_t_we    = 1'b0;
    wb_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_ld_s_valid) begin
          if (s_len_q < SCap) begin
            s_we    = 1'b1;
            s_len_d = s_len_q + SOne;
          end else begin
            err_d = 1'b1;
          end
        end
        if (i_ld_t_valid) begin
          if (t_len_q < TCap) begin
            ld_t_we = 1'b1;
            t_len_d = t_len_q + TOne;
          end else begin
            err_d = 1'b1;
          end
        end
        if (i_start) begin
          if (s_len_q != '0 && t_len_q != '0) begin
            state_d    = StPresent;
            s_ptr_d    = '0;
            t_rd_d     = '0;
            t_wr_d     = '0;
            bank_sel_d = 1'b0;
            err_d      = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      // One-cycle fetch slot: chunk s_ptr and element 0 of the read bank go to the outputs.
      StPresent: begin
        state_d = StServe;
        valid_d = 1'b1;
        s_out_d = s_ram[s_ptr_q[SW-1:0]];
        e_out_d = rd_elem;
      end

      StServe: begin
        if (i_update_t_w) begin
          if (t_wr_q < t_len_q) begin
            wb_we  = 1'b1;
            t_wr_d = t_wr_q + TOne;
            // On the final element the read side holds; only the write-back advances.
            if (t_rd_q != t_len_q - TOne) begin
              t_rd_d  = t_rd_q + TOne;
              e_out_d = rd_elem;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        if (i_update_s_w) begin
          if (i_update_t_w || t_wr_q != t_len_q) begin
            err_d = 1'b1;
          end else if (s_ptr_q == s_len_q - SOne) begin
            state_d = StIdle;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d    = StPresent;
            valid_d    = 1'b0;
            bank_sel_d = ~bank_sel_q;
            s_ptr_d    = s_ptr_q + SOne;
            t_rd_d     = '0;
            t_wr_d     = '0;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // Strobes with nothing presented are protocol errors (also overrides the start clear).
    if (!valid_q && (i_update_t_w || i_update_s_w)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      s_len_q    <= '0;
      t_len_q    <= '0;
      s_ptr_q    <= '0;
      t_rd_q     <= '0;
      t_wr_q     <= '0;
      bank_sel_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      s_out_q    <= '0;
      e_out_q    <= '0;
    end else begin
      state_q    <= state_d;
      s_len_q    <= s_len_d;
      t_len_q    <= t_len_d;
      s_ptr_q    <= s_ptr_d;
      t_rd_q     <= t_rd_d;
      t_wr_q     <= t_wr_d;
      bank_sel_q <= bank_sel_d;
      err_q      <= err_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      s_out_q    <= s_out_d;
      e_out_q    <= e_out_d;
    end
  end

  // Loads only happen in IDLE and write-back only in SERVE, so the bank0 ports never collide.
  always_ff @(posedge clk) begin
    if (s_we) begin
      s_ram[s_len_q[SW-1:0]] <= i_ld_s_data;
    end
    if (ld_t_we) begin
      bank0[t_len_q[AW-1:0]] <= {i_ld_t_data, {(2 * VEF_BIT){1'b0}}};
    end else if (wb_we && bank_sel_q) begin
      bank0[t_wr_q[AW-1:0]] <= wb_data;
    end
    if (wb_we && !bank_sel_q) begin
      bank1[t_wr_q[AW-1:0]] <= wb_data;
    end
  end

  assign o_busy       = (state_q != StIdle);
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_data_valid = valid_q;
  assign o_s          = s_out_q;
  assign o_t          = e_out_q[EW-1 -: 2];
  assign o_v          = e_out_q[2*VEF_BIT-1 -: VEF_BIT];
  assign o_f          = e_out_q[VEF_BIT-1:0];
  assign o_t_last     = valid_q && (t_rd_q == t_len_q - TOne);
  assign o_s_last     = valid_q && (s_ptr_q == s_len_q - SOne);

endmodule
